// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int QDEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAP,
    RESP
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// In-order request queue with registered occupancy count.
module req_fifo
  import sram_ctrl_pkg::*;
#(
  parameter type entry_t = req_t,
  parameter int  DEPTH   = QDEPTH_DEF,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Sequences queued read/write requests onto a single-port synchronous SRAM
// and returns read data over a valid/ready response channel.
//
// state   | meaning
// IDLE    | queue empty, SRAM port parked
// WRITE   | WE high for one cycle with popped addr/din
// RD_ADDR | read address on the SRAM port
// RD_CAP  | dout valid, captured into the response register
// RESP    | response held until rsp_ready
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              WE,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout
);

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  state_t            state_q, state_nxt;
  entry_t            push_entry, head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              issue;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;

  assign push_entry = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign fifo_push  = req_valid && !fifo_full;
  assign req_ready  = (fifo_count != CW'(QDEPTH));

  req_fifo #(
    .entry_t(entry_t),
    .DEPTH  (QDEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_nxt     = state_q;
    issue         = 1'b0;
    fifo_pop      = 1'b0;
    we_nxt        = 1'b0;
    addr_nxt      = addr;
    din_nxt       = din;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;

    case (state_q)
      IDLE:    issue = !fifo_empty;
      WRITE: begin
        if (!fifo_empty) issue = 1'b1;
        else             state_nxt = IDLE;
      end
      RD_ADDR: state_nxt = RD_CAP;
      RD_CAP: begin
        rsp_rdata_nxt = dout;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          if (!fifo_empty) issue = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reads leave din untouched so the port only moves on real writes.
    if (issue) begin
      fifo_pop = 1'b1;
      addr_nxt = head.addr;
      if (head.we) begin
        state_nxt = WRITE;
        we_nxt    = 1'b1;
        din_nxt   = head.wdata;
      end else begin
        state_nxt = RD_ADDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      WE        <= 1'b0;
      addr      <= '0;
      din       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_nxt;
      WE        <= we_nxt;
      addr      <= addr_nxt;
      din       <= din_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural synchronous SRAM.
module tb_sram_req_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          WE;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .WE       (WE),
    .addr     (addr),
    .din      (din),
    .dout     (dout)
  );

  // Synchronous single-port SRAM, read-before-write.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (WE) mem[addr] <= din;
    dout <= mem[addr];
  end

  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];
  logic [DW-1:0] rsp_log[$];
  int            run, max_run;
  bit            seen [64];

  always @(negedge clk) begin
    if (WE === 1'b1) begin
      wa_log.push_back(addr);
      wd_log.push_back(din);
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && reset === 1'b1)
      rsp_log.push_back(rsp_rdata);
    if (!$isunknown(addr)) seen[addr] = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_log.delete();
    wd_log.delete();
    rsp_log.delete();
    run     = 0;
    max_run = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic rdy;
    int   n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    do begin
      rdy = req_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    req_valid = 1'b0;
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL send_accept addr=%0h: got req_ready=%b, need 1 within 50 cycles", a, rdy);
    end
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL wait_rsp_valid: got %b, need 1 within 30 cycles", rsp_valid);
    end
  endtask

  task automatic wait_rsp_count(input int want);
    int n;
    n = 0;
    while (rsp_log.size() < want && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (rsp_log.size() != want) begin
      bad++;
      $display("FAIL rsp_count: got %0d, need %0d", rsp_log.size(), want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 6'h15;
    req_wdata = 8'hA5;
    rsp_ready = 1'b0;
    repeat (3) tick();
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (5) tick();
    total += 6;
    if (WE !== 1'b0) begin bad++; $display("FAIL reset_we: got %b, need 0", WE); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b, need 0", rsp_valid); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b, need 1", req_ready); end
    if (addr !== 6'h00) begin bad++; $display("FAIL reset_addr: got %h, need 00", addr); end
    if (din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h, need 00", din); end
    if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata: got %h, need 00", rsp_rdata); end
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    send(1'b1, 6'h03, 8'h5A);
    total++;
    if (WE !== 1'b0) begin bad++; $display("FAIL wr_not_same_cycle: got WE=%b, need 0", WE); end
    send(1'b0, 6'h03, 8'h00);
    total += 3;
    if (WE !== 1'b1) begin bad++; $display("FAIL wr_we: got %b, need 1", WE); end
    if (addr !== 6'h03) begin bad++; $display("FAIL wr_addr: got %h, need 03", addr); end
    if (din !== 8'h5A) begin bad++; $display("FAIL wr_din: got %h, need 5a", din); end
    tick();
    total += 3;
    if (WE !== 1'b0) begin bad++; $display("FAIL wr_one_cycle: got WE=%b, need 0", WE); end
    if (addr !== 6'h03) begin bad++; $display("FAIL rd_addr: got %h, need 03", addr); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early1: got rsp_valid=%b, need 0", rsp_valid); end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early2: got rsp_valid=%b, need 0", rsp_valid); end
    tick();
    total += 2;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_latency: got rsp_valid=%b, need 1", rsp_valid); end
    if (rsp_rdata !== 8'h5A) begin bad++; $display("FAIL rd_data: got %h, need 5a", rsp_rdata); end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_consumed: got rsp_valid=%b, need 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int   i, stall, i_at_full;
    logic rdy;
    i = 0;
    stall = 0;
    i_at_full = -1;
    clear_logs();
    rsp_ready = 1'b0;
    send(1'b0, 6'h3F, 8'h00);
    for (int c = 0; c < 60 && i < 6; c++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = AW'(i);
      req_wdata = DW'(8'h10 + i);
      rdy = req_ready;
      if (!rdy) begin
        if (i_at_full < 0) i_at_full = i;
        stall++;
        if (stall == 3) rsp_ready = 1'b1;
      end
      tick();
      if (rdy) i++;
    end
    req_valid = 1'b0;
    repeat (8) tick();
    total += 4;
    if (i_at_full !== 4) begin bad++; $display("FAIL b2b_full_at: got %0d queued, need 4", i_at_full); end
    if (i !== 6) begin bad++; $display("FAIL b2b_accepted: got %0d, need 6", i); end
    if (max_run !== 6) begin bad++; $display("FAIL b2b_we_run: got %0d, need 6", max_run); end
    if (wa_log.size() != 6) begin bad++; $display("FAIL b2b_we_count: got %0d, need 6", wa_log.size()); end
    for (int k = 0; k < 6 && k < wa_log.size(); k++) begin
      total += 2;
      if (wa_log[k] !== AW'(k)) begin bad++; $display("FAIL b2b_waddr[%0d]: got %h, need %h", k, wa_log[k], AW'(k)); end
      if (wd_log[k] !== DW'(8'h10 + k)) begin bad++; $display("FAIL b2b_wdata[%0d]: got %h, need %h", k, wd_log[k], DW'(8'h10 + k)); end
    end
    rsp_log.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) send(1'b0, AW'(k), 8'h00);
    wait_rsp_count(6);
    for (int k = 0; k < 6 && k < rsp_log.size(); k++) begin
      total++;
      if (rsp_log[k] !== DW'(8'h10 + k)) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h, need %h", k, rsp_log[k], DW'(8'h10 + k)); end
    end
  endtask

  task automatic test_rsp_hold();
    rsp_ready = 1'b0;
    send(1'b0, 6'h01, 8'h00);
    send(1'b1, 6'h01, 8'hEE);
    wait_rsp_valid();
    for (int k = 0; k < 10; k++) begin
      total += 3;
      if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b, need 1", k, rsp_valid); end
      if (rsp_rdata !== 8'h11) begin bad++; $display("FAIL hold_rdata[%0d]: got %h, need 11", k, rsp_rdata); end
      if (WE !== 1'b0) begin bad++; $display("FAIL hold_no_write[%0d]: got WE=%b, need 0", k, WE); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total += 4;
    if (WE !== 1'b1) begin bad++; $display("FAIL hold_wr_we: got %b, need 1", WE); end
    if (addr !== 6'h01) begin bad++; $display("FAIL hold_wr_addr: got %h, need 01", addr); end
    if (din !== 8'hEE) begin bad++; $display("FAIL hold_wr_din: got %h, need ee", din); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_rsp_cleared: got %b, need 0", rsp_valid); end
    tick();
    rsp_log.delete();
    send(1'b0, 6'h01, 8'h00);
    wait_rsp_count(1);
    if (rsp_log.size() > 0) begin
      total++;
      if (rsp_log[0] !== 8'hEE) begin bad++; $display("FAIL hold_reread: got %h, need ee", rsp_log[0]); end
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    send(1'b0, 6'h30, 8'h00);
    send(1'b1, 6'h10, 8'h77);
    send(1'b1, 6'h20, 8'h01);
    send(1'b1, 6'h21, 8'h02);
    send(1'b1, 6'h22, 8'h03);
    wait_rsp_valid();
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_full: got req_ready=%b, need 0", req_ready); end
    rsp_ready = 1'b1;
    tick();
    total += 2;
    if (WE !== 1'b1) begin bad++; $display("FAIL mid_wr_we: got %b, need 1", WE); end
    if (addr !== 6'h10) begin bad++; $display("FAIL mid_wr_addr: got %h, need 10", addr); end
    reset = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 6'h2A;
    req_wdata = 8'h99;
    tick();
    total += 4;
    if (WE !== 1'b0) begin bad++; $display("FAIL mid_we_cleared: got %b, need 0", WE); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_cleared: got %b, need 0", rsp_valid); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b, need 1", req_ready); end
    if (addr !== 6'h00) begin bad++; $display("FAIL mid_addr: got %h, need 00", addr); end
    tick();
    clear_logs();
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (10) tick();
    total += 7;
    if (wa_log.size() != 0) begin bad++; $display("FAIL mid_no_writes: got %0d, need 0", wa_log.size()); end
    if (seen[6'h20]) begin bad++; $display("FAIL mid_addr20: got seen=1, need 0"); end
    if (seen[6'h21]) begin bad++; $display("FAIL mid_addr21: got seen=1, need 0"); end
    if (seen[6'h22]) begin bad++; $display("FAIL mid_addr22: got seen=1, need 0"); end
    if (seen[6'h2A]) begin bad++; $display("FAIL mid_addr2a: got seen=1, need 0"); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_idle: got %b, need 0", rsp_valid); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_idle: got %b, need 1", req_ready); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    clear_logs();
    reset = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request-side controller sitting directly upstream of the `sram` block. It accepts read/write requests over a valid/ready handshake and buffers them in a small in-order queue. It sequences them onto the SRAM's single `WE`/`addr`/`din` port, captures read data from `dout`, and returns it over a valid/ready response channel. It is the only master of the SRAM port.

## Interface
- `ADDR_W`, 6: SRAM address width.
- `DATA_W`, 8: SRAM data width.
- `QDEPTH`, 4: request queue depth; power of two, ≥2.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset, sampled on `clk`).
- `req_valid` in 1: upstream request present.
- `req_ready` out 1: queue can accept; equals `!full`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: request address.
- `req_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: downstream accepts response.
- `rsp_rdata` out DATA_W: read data.
- `WE` out 1: SRAM write enable.
- `addr` out ADDR_W: SRAM address.
- `din` out DATA_W: SRAM write data.
- `dout` in DATA_W: SRAM read data; valid one cycle after the address edge with `WE`=0.

## Operation
- Queue:
  - Request pushed on any edge with `req_valid && req_ready`.
  - FIFO order; no bypass, so a request is never issued in its acceptance cycle.
- FSM states:
  - IDLE: queue empty.
    - Queue non-empty → pop and issue; write → WRITE, read → RD_ADDR.
  - WRITE: `WE`=1, `addr`/`din` from popped entry for exactly one cycle.
    - Queue non-empty → pop and issue next (back-to-back writes at 1/cycle).
    - Else → IDLE.
  - RD_ADDR: `WE`=0, `addr` driven → RD_CAP.
  - RD_CAP: `dout` captured into `rsp_rdata`, `rsp_valid` set → RESP.
  - RESP: hold `rsp_valid`/`rsp_rdata` stable until `rsp_ready`.
    - On the handshake edge, pop the next entry if present, else → IDLE.
- Ordering:
  - Strictly in order; no request issues while a read is in RD_ADDR, RD_CAP or RESP.
  - Write-after-read to the same address therefore returns old data.
- `WE` is 1 only in WRITE.
- `addr`/`din` hold their last values when idle.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `WE`=0, `addr`=0, `din`=0, FSM=IDLE, queue empty.

## Timing
- All outputs registered; `req_ready` derives from the registered occupancy count.
- Write: accepted at edge k → `WE`=1 in the cycle after edge k+1 → SRAM writes at edge k+2.
- Read:
  - Accepted at edge k → `addr` after edge k+1 → `dout` valid after edge k+2 → `rsp_valid`=1 after edge k+3.
  - Read latency is 3 cycles plus queueing.
- Full queue:
  - `req_ready`=0.
  - A pop in the same cycle does not raise `req_ready` until the next cycle.
- Simultaneous push and pop on a non-full queue: occupancy unchanged; pointers wrap modulo QDEPTH.
- `rsp_ready` held high: a response is consumed on the cycle `rsp_valid` rises, and the FSM pops the next entry on that same edge.
- `req_valid` while `reset`=0: ignored.
- Reset mid-operation:
  - Queue flushed, in-flight read dropped, `rsp_valid` cleared.
  - `WE` forced to 0 on the reset edge; no partial write is ever extended.

## Structure
- Package `sram_ctrl_pkg`:
  - Default ADDR_W/DATA_W/QDEPTH constants.
  - `state_t` enum (IDLE, WRITE, RD_ADDR, RD_CAP, RESP).
  - Packed `req_t` struct {we, addr, wdata}.
- Sub-module `req_fifo`:
  - Parameterised synchronous FIFO of `req_t`.
  - Ports: push/pop, full/empty, count.
  - Same `clk`/`reset` convention.
- Top: FSM, SRAM port registers, response register.

## Test plan
- Reset, then idle 5 cycles → `WE`=0, `rsp_valid`=0, `req_ready`=1, `addr`=0.
- Write 0x5A to 0x03, then read 0x03 with `rsp_ready`=1 → `WE` pulses one cycle with `addr`=0x03, `din`=0x5A; `rsp_rdata`=0x5A exactly 3 cycles after read acceptance.
- Six back-to-back writes (addr 0..5, data 0x10..0x15) with `req_valid` held → `WE` high 6 consecutive cycles; `req_ready` drops when 4 are queued; reads of 0..5 return 0x10..0x15 in order.
- Read 0x01 with `rsp_ready`=0 for 10 cycles, with a queued write to 0x01 (0xEE) → `rsp_valid` and `rsp_rdata` stable for all 10 cycles, write not issued; after the handshake, the write issues on the next cycle and a re-read returns 0xEE.
- Assert `reset`=0 the cycle after a write is issued with 3 requests queued → `WE`=0 after that edge; `rsp_valid`=0; queue empty; none of the queued requests ever appear on `addr`.
